// File: rtl/loop_ctrl.sv
// Loop controller for a bracket-style interpreter: pushes loop start addresses,
// redirects fetch on a taken ']' and skips loop bodies entered with a zero cell.
module loop_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [1:0]       op_code,
   input  logic [WIDTH-1:0] pc,
   input  logic             cell_zero,
   output logic             jump,
   output logic [WIDTH-1:0] jump_pc,
   output logic             skip,
   output logic [DEPTH:0]   sp,
   output logic [DEPTH-1:0] stk_ra,
   input  logic [WIDTH-1:0] stk_rd,
   output logic             stk_we,
   output logic [DEPTH-1:0] stk_wa,
   output logic [WIDTH-1:0] stk_wd,
   output logic             err_overflow,
   output logic             err_underflow
);

   localparam logic [DEPTH:0]   SpOne = {{DEPTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] WOne  = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StJump, StSkip, StError} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] nest_q;

   logic             accept;
   logic             is_open;
   logic             is_close;
   logic             full;
   logic             empty;
   logic             push_ok;
   logic [DEPTH:0]   sp_m1;

   assign accept   = op_valid & op_ready;
   assign is_open  = (op_code == 2'b01);
   assign is_close = (op_code == 2'b10);
   // Occupancy never exceeds 2**DEPTH, so the top bit alone means full.
   assign full     = sp[DEPTH];
   assign empty    = (sp == '0);
   assign sp_m1    = sp - SpOne;

   assign push_ok = (state_q == StIdle) & accept & is_open & ~cell_zero & ~full;
   assign stk_we  = rst_n & push_ok;
   assign stk_wa  = sp[DEPTH-1:0];
   assign stk_wd  = pc;
   assign stk_ra  = sp_m1[DEPTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         sp            <= '0;
         nest_q        <= '0;
         jump          <= 1'b0;
         jump_pc       <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
         op_ready      <= 1'b1;
         skip          <= 1'b0;
      end else begin
         jump <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept && is_open) begin
                  if (cell_zero) begin
                     nest_q  <= WOne;
                     skip    <= 1'b1;
                     state_q <= StSkip;
                  end else if (full) begin
                     err_overflow <= 1'b1;
                     op_ready     <= 1'b0;
                     state_q      <= StError;
                  end else begin
                     sp <= sp + SpOne;
                  end
               end else if (accept && is_close) begin
                  if (empty) begin
                     err_underflow <= 1'b1;
                     op_ready      <= 1'b0;
                     state_q       <= StError;
                  end else if (!cell_zero) begin
                     // Resume just after the matching '['.
                     jump_pc  <= stk_rd + WOne;
                     jump     <= 1'b1;
                     op_ready <= 1'b0;
                     state_q  <= StJump;
                  end else begin
                     sp <= sp - SpOne;
                  end
               end
            end
            StJump: begin
               op_ready <= 1'b1;
               state_q  <= StIdle;
            end
            StSkip: begin
               if (accept && is_open) begin
                  nest_q <= nest_q + WOne;
               end else if (accept && is_close) begin
                  if (nest_q > WOne) begin
                     nest_q <= nest_q - WOne;
                  end else begin
                     nest_q  <= '0;
                     skip    <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            StError: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_loop_ctrl.sv
// Randomized bench for loop_ctrl against a queue-based model of the loop stack
// and skip nesting, plus directed loop, skip, overflow, underflow and reset cases.
module tb_loop_ctrl;

   localparam int DEPTH = 4;
   localparam int WIDTH = 16;
   localparam int N     = 2 ** DEPTH;

   localparam int MIdle = 0;
   localparam int MJump = 1;
   localparam int MSkip = 2;
   localparam int MErr  = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             op_valid;
   logic             op_ready;
   logic [1:0]       op_code;
   logic [WIDTH-1:0] pc;
   logic             cell_zero;
   logic             jump;
   logic [WIDTH-1:0] jump_pc;
   logic             skip;
   logic [DEPTH:0]   sp;
   logic [DEPTH-1:0] stk_ra;
   logic [WIDTH-1:0] stk_rd;
   logic             stk_we;
   logic [DEPTH-1:0] stk_wa;
   logic [WIDTH-1:0] stk_wd;
   logic             err_overflow;
   logic             err_underflow;

   logic [WIDTH-1:0] mem [N];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int               m_mode = MIdle;
   logic [WIDTH-1:0] m_stack[$];
   int               m_nest = 0;
   bit               m_ovf = 1'b0;
   bit               m_unf = 1'b0;
   bit               m_jump = 1'b0;
   logic [WIDTH-1:0] m_jpc = '0;

   always #5 clk = ~clk;

   assign stk_rd = mem[stk_ra];
   always @(posedge clk) if (stk_we) mem[stk_wa] <= stk_wd;

   loop_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_code      (op_code),
      .pc           (pc),
      .cell_zero    (cell_zero),
      .jump         (jump),
      .jump_pc      (jump_pc),
      .skip         (skip),
      .sp           (sp),
      .stk_ra       (stk_ra),
      .stk_rd       (stk_rd),
      .stk_we       (stk_we),
      .stk_wa       (stk_wa),
      .stk_wd       (stk_wd),
      .err_overflow (err_overflow),
      .err_underflow(err_underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive, check same-cycle stack write port, advance model, check registers.
   task automatic step(input bit v, input logic [1:0] c, input logic [WIDTH-1:0] p,
                       input bit cz, input bit r);
      bit exp_we;
      int sz;
      op_valid  = v;
      op_code   = c;
      pc        = p;
      cell_zero = cz;
      rst_n     = r;
      #3;
      sz     = m_stack.size();
      exp_we = r && (m_mode == MIdle) && v && (c == 2'b01) && !cz && (sz < N);
      check("stk_we", 32'(stk_we), 32'(exp_we));
      if (exp_we) begin
         check("stk_wa", 32'(stk_wa), 32'(sz));
         check("stk_wd", 32'(stk_wd), 32'(p));
      end
      check("stk_ra", 32'(stk_ra), 32'((sz - 1) & (N - 1)));

      if (!r) begin
         m_mode = MIdle;
         m_stack.delete();
         m_nest = 0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_jump = 1'b0;
         m_jpc  = '0;
      end else begin
         m_jump = 1'b0;
         case (m_mode)
            MJump: m_mode = MIdle;
            MIdle: if (v) begin
               if (c == 2'b01) begin
                  if (cz) begin
                     m_nest = 1;
                     m_mode = MSkip;
                  end else if (sz == N) begin
                     m_ovf  = 1'b1;
                     m_mode = MErr;
                  end else begin
                     m_stack.push_back(p);
                  end
               end else if (c == 2'b10) begin
                  if (sz == 0) begin
                     m_unf  = 1'b1;
                     m_mode = MErr;
                  end else if (!cz) begin
                     m_jpc  = m_stack[$] + 16'd1;
                     m_jump = 1'b1;
                     m_mode = MJump;
                  end else begin
                     void'(m_stack.pop_back());
                  end
               end
            end
            MSkip: if (v) begin
               if (c == 2'b01) m_nest++;
               else if (c == 2'b10) begin
                  if (m_nest > 1) m_nest--;
                  else begin
                     m_nest = 0;
                     m_mode = MIdle;
                  end
               end
            end
            default: ;
         endcase
      end

      @(posedge clk);
      #1;
      check("op_ready", 32'(op_ready), 32'((m_mode == MIdle) || (m_mode == MSkip)));
      check("skip", 32'(skip), 32'(m_mode == MSkip));
      check("jump", 32'(jump), 32'(m_jump));
      check("sp", 32'(sp), 32'(m_stack.size()));
      check("err_overflow", 32'(err_overflow), 32'(m_ovf));
      check("err_underflow", 32'(err_underflow), 32'(m_unf));
      if (m_jump || !r) check("jump_pc", 32'(jump_pc), 32'(m_jpc));
   endtask

   task automatic do_reset();
      step(1'b0, 2'b00, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int czp;
      int sel;
      bit v;
      bit r;
      bit cz;
      logic [1:0] c;
      logic [WIDTH-1:0] p;
      int czps[6] = '{10, 50, 0, 30, 2, 70};

      rst_n     = 1'b0;
      op_valid  = 1'b0;
      op_code   = 2'b00;
      pc        = '0;
      cell_zero = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      do_reset();
      check("reset_op_ready", 32'(op_ready), 32'd1);
      check("reset_sp", 32'(sp), 32'd0);

      // Push then taken loop-back, then loop exit.
      step(1'b1, 2'b01, 16'd5, 1'b0, 1'b1);
      check("push_sp", 32'(sp), 32'd1);
      step(1'b1, 2'b10, 16'd9, 1'b0, 1'b1);
      check("loop_jump", 32'(jump), 32'd1);
      check("loop_jump_pc", 32'(jump_pc), 32'd6);
      check("loop_ready", 32'(op_ready), 32'd0);
      step(1'b1, 2'b01, 16'd7, 1'b0, 1'b1);
      check("jump_ignores_op_sp", 32'(sp), 32'd1);
      check("jump_one_cycle", 32'(jump), 32'd0);
      step(1'b1, 2'b10, 16'd10, 1'b1, 1'b1);
      check("exit_sp", 32'(sp), 32'd0);
      check("exit_jump", 32'(jump), 32'd0);

      // Nested skip.
      step(1'b1, 2'b01, 16'd20, 1'b1, 1'b1);
      check("skip_enter", 32'(skip), 32'd1);
      step(1'b1, 2'b01, 16'd21, 1'b0, 1'b1);
      step(1'b1, 2'b00, 16'd22, 1'b0, 1'b1);
      step(1'b1, 2'b10, 16'd23, 1'b0, 1'b1);
      check("skip_inner_close", 32'(skip), 32'd1);
      step(1'b1, 2'b10, 16'd24, 1'b0, 1'b1);
      check("skip_exit", 32'(skip), 32'd0);

      // Overflow.
      do_reset();
      for (int i = 0; i < N; i++) step(1'b1, 2'b01, 16'(i), 1'b0, 1'b1);
      check("full_sp", 32'(sp), 32'd16);
      step(1'b1, 2'b01, 16'd99, 1'b0, 1'b1);
      check("ovf_flag", 32'(err_overflow), 32'd1);
      for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 16'd0, 1'b0, 1'b1);
      check("ovf_absorb_ready", 32'(op_ready), 32'd0);
      check("ovf_sp", 32'(sp), 32'd16);

      // Underflow, then reset clears.
      do_reset();
      step(1'b1, 2'b10, 16'd3, 1'b0, 1'b1);
      check("unf_flag", 32'(err_underflow), 32'd1);
      check("unf_jump", 32'(jump), 32'd0);
      step(1'b1, 2'b00, 16'd0, 1'b0, 1'b0);
      check("unf_reset_flag", 32'(err_underflow), 32'd0);
      check("unf_reset_ready", 32'(op_ready), 32'd1);

      // Reset mid-skip with nesting and a non-empty stack.
      step(1'b1, 2'b01, 16'd40, 1'b0, 1'b1);
      step(1'b1, 2'b01, 16'd41, 1'b0, 1'b1);
      step(1'b1, 2'b01, 16'd42, 1'b1, 1'b1);
      step(1'b1, 2'b01, 16'd43, 1'b1, 1'b1);
      step(1'b1, 2'b01, 16'd44, 1'b0, 1'b1);
      step(1'b1, 2'b10, 16'd45, 1'b0, 1'b0);
      check("midskip_reset_skip", 32'(skip), 32'd0);
      check("midskip_reset_sp", 32'(sp), 32'd0);
      step(1'b1, 2'b01, 16'd46, 1'b1, 1'b1);
      step(1'b1, 2'b10, 16'd47, 1'b0, 1'b1);
      check("nest_cleared", 32'(skip), 32'd0);

      // Randomized segments with varying zero-cell bias.
      for (int b = 0; b < 6; b++) begin
         czp = czps[b];
         for (int k = 0; k < 500; k++) begin
            r   = ($urandom_range(0, 149) != 0);
            v   = ($urandom_range(0, 4) != 0);
            sel = $urandom_range(0, 99);
            if (sel < 45) c = 2'b01;
            else if (sel < 80) c = 2'b10;
            else c = $urandom_range(0, 1) ? 2'b00 : 2'b11;
            cz = ($urandom_range(0, 99) < czp);
            p  = 16'($urandom);
            step(v, c, p, cz, r);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
